// File: rtl/vga_timing_gen.sv
// Parametrised VGA sync/timing generator with a pixel-request stage and a
// latency-matched display pipeline that blanks R/G/B outside active video.
module vga_timing_gen #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 23,
    parameter int CNT_W    = 11,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int PIX_LAT  = 2,
    parameter int COL_W    = 1
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             ce,
    output logic             req,
    output logic [CNT_W-1:0] req_x,
    output logic [CNT_W-1:0] req_y,
    input  logic [COL_W-1:0] dat_r,
    input  logic [COL_W-1:0] dat_g,
    input  logic [COL_W-1:0] dat_b,
    output logic             hsync,
    output logic             vsync,
    output logic             active,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             line_start,
    output logic             frame_start,
    output logic [COL_W-1:0] R,
    output logic [COL_W-1:0] G,
    output logic [COL_W-1:0] B
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_SYNC_S = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SYNC_E = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_SYNC_S = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SYNC_E = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);

    localparam logic HS_ON = (HS_POL != 0);
    localparam logic VS_ON = (VS_POL != 0);

    logic [CNT_W-1:0] hc;
    logic [CNT_W-1:0] vc;

    // Index 0 is the request stage; index PIX_LAT is the display stage.
    logic             act_p [0:PIX_LAT];
    logic             hs_p  [0:PIX_LAT];
    logic             vs_p  [0:PIX_LAT];
    logic             ls_p  [0:PIX_LAT];
    logic             fs_p  [0:PIX_LAT];
    logic [CNT_W-1:0] x_p   [0:PIX_LAT];
    logic [CNT_W-1:0] y_p   [0:PIX_LAT];

    logic pix_act;
    logic in_hs;
    logic in_vs;
    logic hc_zero;

    assign pix_act = (hc < H_ACT_C) && (vc < V_ACT_C);
    assign in_hs   = (hc >= H_SYNC_S) && (hc < H_SYNC_E);
    assign in_vs   = (vc >= V_SYNC_S) && (vc < V_SYNC_E);
    assign hc_zero = (hc == '0);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            hc <= '0;
            vc <= '0;
            for (int i = 0; i <= PIX_LAT; i++) begin
                act_p[i] <= 1'b0;
                hs_p[i]  <= ~HS_ON;
                vs_p[i]  <= ~VS_ON;
                ls_p[i]  <= 1'b0;
                fs_p[i]  <= 1'b0;
                x_p[i]   <= '0;
                y_p[i]   <= '0;
            end
            R <= '0;
            G <= '0;
            B <= '0;
        end else if (ce) begin
            // Counter stage
            if (hc == H_LAST) begin
                hc <= '0;
                vc <= (vc == V_LAST) ? '0 : vc + 1'b1;
            end else begin
                hc <= hc + 1'b1;
            end

            // Request stage
            act_p[0] <= pix_act;
            hs_p[0]  <= in_hs ? HS_ON : ~HS_ON;
            vs_p[0]  <= in_vs ? VS_ON : ~VS_ON;
            ls_p[0]  <= pix_act && hc_zero;
            fs_p[0]  <= pix_act && hc_zero && (vc == '0);
            x_p[0]   <= pix_act ? hc : '0;
            y_p[0]   <= pix_act ? vc : '0;

            // Delay stages up to the display stage
            for (int i = 1; i <= PIX_LAT; i++) begin
                act_p[i] <= act_p[i-1];
                hs_p[i]  <= hs_p[i-1];
                vs_p[i]  <= vs_p[i-1];
                ls_p[i]  <= ls_p[i-1];
                fs_p[i]  <= fs_p[i-1];
                x_p[i]   <= x_p[i-1];
                y_p[i]   <= y_p[i-1];
            end

            // Colour is captured on the same edge the display stage loads, so
            // the gate is the active flag about to enter the display stage.
            R <= act_p[PIX_LAT-1] ? dat_r : '0;
            G <= act_p[PIX_LAT-1] ? dat_g : '0;
            B <= act_p[PIX_LAT-1] ? dat_b : '0;
        end
    end

    assign req         = act_p[0];
    assign req_x       = x_p[0];
    assign req_y       = y_p[0];
    assign hsync       = hs_p[PIX_LAT];
    assign vsync       = vs_p[PIX_LAT];
    assign active      = act_p[PIX_LAT];
    assign x           = x_p[PIX_LAT];
    assign y           = y_p[PIX_LAT];
    assign line_start  = ls_p[PIX_LAT];
    assign frame_start = fs_p[PIX_LAT];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two small-timing instances (both sync polarities)
// checked every cycle against a coordinate-arithmetic model plus literal pins.
module tb_vga_timing_gen;

    localparam int HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;   // 15
    localparam int VT = VA + VF + VS + VB;   // 8
    localparam int LAT = 2;
    localparam int CW = 8;
    localparam int COL = 1;

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    logic ce = 1'b1;
    logic toggle = 1'b0;
    logic [COL-1:0] dat_r = '1, dat_g = '1, dat_b = '1;

    logic rq0, hs0, vs0, ac0, ls0, fs0;
    logic [CW-1:0] rx0, ry0, px0, py0;
    logic [COL-1:0] r0, g0, b0;
    logic rq1, hs1, vs1, ac1, ls1, fs1;
    logic [CW-1:0] rx1, ry1, px1, py1;
    logic [COL-1:0] r1, g1, b1;

    int checks = 0;
    int errors = 0;
    int n;   // ce edges since reset release

    vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .CNT_W(CW),
        .HS_POL(0), .VS_POL(0), .PIX_LAT(LAT), .COL_W(COL)) u_dut (
        .clk(clk), .clr_n(clr_n), .ce(ce), .req(rq0), .req_x(rx0), .req_y(ry0),
        .dat_r(dat_r), .dat_g(dat_g), .dat_b(dat_b), .hsync(hs0), .vsync(vs0),
        .active(ac0), .x(px0), .y(py0), .line_start(ls0), .frame_start(fs0),
        .R(r0), .G(g0), .B(b0));

    vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .CNT_W(CW),
        .HS_POL(1), .VS_POL(1), .PIX_LAT(LAT), .COL_W(COL)) u_pol (
        .clk(clk), .clr_n(clr_n), .ce(ce), .req(rq1), .req_x(rx1), .req_y(ry1),
        .dat_r(dat_r), .dat_g(dat_g), .dat_b(dat_b), .hsync(hs1), .vsync(vs1),
        .active(ac1), .x(px1), .y(py1), .line_start(ls1), .frame_start(fs1),
        .R(r1), .G(g1), .B(b1));

    always #5 clk = ~clk;

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) n <= 0;
        else if (ce) n <= n + 1;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, got, want, $time);
        end
    endtask

    function automatic logic pat(input int h, input int v, input int ch);
        case (ch)
            0: pat = h[0];
            1: pat = v[0];
            default: pat = h[1] ^ v[0];
        endcase
    endfunction

    // Source model: the pixel sampled on the next ce edge is frame position n-LAT.
    always begin
        int p, h, v;
        @(posedge clk);
        #1;
        ce = toggle ? ~ce : 1'b1;
        p = n - LAT;
        if (p < 0) begin
            dat_r = '1; dat_g = '1; dat_b = '1;
        end else begin
            h = p % HT;
            v = (p / HT) % VT;
            if (h < HA && v < VA) begin
                dat_r = pat(h, v, 0); dat_g = pat(h, v, 1); dat_b = pat(h, v, 2);
            end else begin
                dat_r = '1; dat_g = '1; dat_b = '1;
            end
        end
    end

    task automatic check_dut(input string t, input logic pol, input logic rq,
        input logic [CW-1:0] rx, input logic [CW-1:0] ry, input logic hs, input logic vs,
        input logic ac, input logic [CW-1:0] px, input logic [CW-1:0] py,
        input logic ls, input logic fs, input logic [COL-1:0] r, input logic [COL-1:0] g,
        input logic [COL-1:0] b);
        int p, h, v;
        logic a;
        if (n < 1) begin
            chk({t, "_req"}, rq, 0); chk({t, "_req_x"}, rx, 0); chk({t, "_req_y"}, ry, 0);
        end else begin
            p = n - 1; h = p % HT; v = (p / HT) % VT; a = (h < HA) && (v < VA);
            chk({t, "_req"}, rq, a);
            chk({t, "_req_x"}, rx, a ? h : 0);
            chk({t, "_req_y"}, ry, a ? v : 0);
        end
        if (n < 1 + LAT) begin
            chk({t, "_hsync"}, hs, !pol); chk({t, "_vsync"}, vs, !pol);
            chk({t, "_active"}, ac, 0); chk({t, "_x"}, px, 0); chk({t, "_y"}, py, 0);
            chk({t, "_line_start"}, ls, 0); chk({t, "_frame_start"}, fs, 0);
            chk({t, "_rgb"}, {r, g, b}, 0);
        end else begin
            p = n - 1 - LAT; h = p % HT; v = (p / HT) % VT; a = (h < HA) && (v < VA);
            chk({t, "_hsync"}, hs, (h >= HA + HF && h < HA + HF + HS) ? pol : !pol);
            chk({t, "_vsync"}, vs, (v >= VA + VF && v < VA + VF + VS) ? pol : !pol);
            chk({t, "_active"}, ac, a);
            chk({t, "_x"}, px, a ? h : 0);
            chk({t, "_y"}, py, a ? v : 0);
            chk({t, "_line_start"}, ls, a && h == 0);
            chk({t, "_frame_start"}, fs, a && h == 0 && v == 0);
            chk({t, "_rgb"}, {r, g, b}, a ? {pat(h, v, 0), pat(h, v, 1), pat(h, v, 2)} : 3'b000);
        end
    endtask

    always @(negedge clk) begin
        check_dut("d0", 1'b0, rq0, rx0, ry0, hs0, vs0, ac0, px0, py0, ls0, fs0, r0, g0, b0);
        check_dut("d1", 1'b1, rq1, rx1, ry1, hs1, vs1, ac1, px1, py1, ls1, fs1, r1, g1, b1);
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int na, nhs, first_hs, nls, nvs, first_vs, maxy, len, found;
        int fs_pos[$];
        logic prev;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_hsync", hs0, 1); chk("rst_vsync", vs0, 1);
        chk("rst_pol_hsync", hs1, 0); chk("rst_pol_vsync", vs1, 0);
        @(posedge clk); #2 clr_n = 1'b1;

        @(posedge clk); #3;
        chk("first_req", rq0, 1); chk("first_req_x", rx0, 0); chk("first_req_y", ry0, 0);
        chk("fs_lat0", fs0, 0);
        @(posedge clk); #3 chk("fs_lat1", fs0, 0);
        @(posedge clk); #3 chk("fs_lat2", fs0, 1);

        na = 0; nhs = 0; first_hs = -1; nls = 0;
        for (int i = 0; i < HT; i++) begin
            @(negedge clk);
            if (ac0) na++;
            if (!hs0) begin nhs++; if (first_hs < 0) first_hs = i; end
            if (ls0) nls++;
        end
        chk("line_active_cnt", na, 8);
        chk("line_hsync_len", nhs, 3);
        chk("line_hsync_start", first_hs, 10);
        chk("line_start_cnt", nls, 1);

        nvs = 0; first_vs = -1; maxy = 0;
        for (int i = HT; i < HT + 2 * HT * VT; i++) begin
            @(negedge clk);
            if (fs0) fs_pos.push_back(i);
            if (!vs0) begin nvs++; if (first_vs < 0) first_vs = i; end
            if (ac0 && int'(py0) > maxy) maxy = int'(py0);
        end
        chk("frame_start_cnt", fs_pos.size(), 2);
        chk("frame_start_pos", (fs_pos.size() > 0) ? fs_pos[0] : -1, 120);
        chk("frame_period", (fs_pos.size() > 1) ? fs_pos[1] - fs_pos[0] : -1, 120);
        chk("vsync_start", first_vs, 75);
        chk("vsync_low_cnt", nvs, 60);
        chk("max_y", maxy, 3);

        toggle = 1'b1;
        found = 0;
        @(negedge clk); prev = hs0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            @(negedge clk);
            if (prev && !hs0) found = 1;
            prev = hs0;
        end
        chk("ce_hsync_found", found, 1);
        len = found;
        for (int i = 0; i < 50 && found == 1; i++) begin
            @(negedge clk);
            if (!hs0) len++;
            else found = 2;
        end
        chk("ce_hsync_len", len, 6);
        toggle = 1'b0;

        found = 0;
        for (int i = 0; i < 300 && found == 0; i++) begin
            @(negedge clk);
            if (rq0 && ry0 == 2 && rx0 == 5) found = 1;
        end
        chk("mid_point_found", found, 1);
        @(posedge clk); #2 clr_n = 1'b0;
        #1;
        chk("async_req", rq0, 0); chk("async_req_x", rx0, 0);
        chk("async_active", ac0, 0); chk("async_x", px0, 0);
        chk("async_hsync", hs0, 1); chk("async_pol_hsync", hs1, 0);
        chk("async_pol_vsync", vs1, 0); chk("async_R", r0, 0);
        repeat (2) @(posedge clk);
        #2 clr_n = 1'b1;
        repeat (150) @(posedge clk);
        #3;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 800x600 sync generator in the GPU path.
- Generates h/v sync with selectable polarity, an active-video flag, pixel coordinates and line/frame strobes.
- Issues a pixel request ahead of display so the frame-buffer reader can return RGB data with a fixed, parametrised latency.
- Blanks colour outside active video. Sits between the frame-buffer read port and the VGA pins.

Parameters:
H_ACTIVE, 800, visible pixels per line
H_FP, 40, horizontal front porch (pixels)
H_SYNC, 128, horizontal sync width
H_BP, 88, horizontal back porch
V_ACTIVE, 600, visible lines per frame
V_FP, 1, vertical front porch (lines)
V_SYNC, 4, vertical sync width
V_BP, 23, vertical back porch
CNT_W, 11, counter / coordinate width; must hold H_TOTAL-1 and V_TOTAL-1
HS_POL, 0, hsync asserted level (0 = active-low)
VS_POL, 0, vsync asserted level
PIX_LAT, 2, ce-cycles from req to valid dat_* (legal range 1..4)
COL_W, 1, bits per colour channel

Ports:
clk  in  1  pixel-domain clock
clr_n  in  1  asynchronous active-low reset
ce  in  1  pixel clock enable; all state advances only when ce=1
req  out  1  pixel data request for coordinate (req_x, req_y)
req_x  out  CNT_W  requested column
req_y  out  CNT_W  requested row
dat_r  in  COL_W  red data, valid PIX_LAT ce-cycles after req
dat_g  in  COL_W  green data
dat_b  in  COL_W  blue data
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
active  out  1  visible pixel on R/G/B this cycle
x  out  CNT_W  column of pixel currently on R/G/B
y  out  CNT_W  row of pixel currently on R/G/B
line_start  out  1  one ce-cycle pulse with first pixel of every line (x=0)
frame_start  out  1  one ce-cycle pulse with pixel (0,0)
R  out  COL_W  red output
G  out  COL_W  green output
B  out  COL_W  blue output

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1056); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (628).
- Line order: active, front porch, sync, back porch. The same order applies vertically.
- Internal counters hc, vc advance on clk when ce=1.
  - hc wraps from H_TOTAL-1 to 0; vc increments on that same wrap.
  - vc wraps from V_TOTAL-1 to 0 when hc also wraps.
  - When ce=0, every register (counters and pipeline) holds.
- Request stage, registered from the counters:
  - req = (hc<H_ACTIVE)&&(vc<V_ACTIVE); req_x=hc; req_y=vc.
  - req_x and req_y are driven 0 whenever req=0.
- Display stage: hsync, vsync, active, x, y, line_start and frame_start are the request-stage values delayed exactly PIX_LAT ce-cycles through a shift pipeline.
  - This aligns them with dat_*.
  - hsync = HS_POL when H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC (evaluated at request stage), else !HS_POL. vsync is defined likewise.
- R/G/B are registered on ce: dat_* when the display-stage active=1, else 0. They are therefore in the same cycle as the displayed x/y/active.
- line_start: 1 when display-stage x=0 and the row is active. frame_start: 1 only at x=0, y=0.
- Reset (clr_n=0, asynchronous, any cycle including mid-frame):
  - hc=vc=0; all pipeline stages cleared.
  - req=0, active=0, line_start=0, frame_start=0, x=y=req_x=req_y=0, R=G=B=0.
  - hsync=!HS_POL, vsync=!VS_POL.
- After clr_n rises:
  - First ce-cycle: request stage presents (0,0), req=1.
  - frame_start appears PIX_LAT ce-cycles later.
  - Pipeline contents from before reset are never emitted.
- No backpressure: dat_* is sampled unconditionally at the aligned stage; a late source is the source's fault.

Test Plan:
- Reset values: hold clr_n=0 with ce=1 -> all outputs at reset values (hsync=vsync=1 for default polarity); release -> req=1, req_x=0, req_y=0 after the first ce edge; frame_start is 1 exactly PIX_LAT=2 ce-cycles later.
- Line timing (ce=1): count one line -> active high 800 cycles; hsync low 128 cycles starting 840 cycles after active rises; period 1056 cycles; line_start once per visible line.
- Frame timing: run 2 frames -> vsync low for 4 lines starting 601 lines after frame_start; frame_start period 1056*628 = 663168 cycles; y wraps 599 -> blank -> 0.
- Latency alignment: drive dat_r = req_x[0] delayed 2 ce-cycles -> R equals x[0] on every active cycle; R=G=B=0 throughout blanking even with dat_*=all-ones.
- Clock enable: ce toggling 1,0,1,0 -> every period doubles (hsync low 256 clk); outputs stable while ce=0.
- Mid-frame reset and polarity: pulse clr_n low at vc=300, hc=500 -> outputs go to reset values immediately (asynchronously), restart at (0,0); rebuild with HS_POL=1, VS_POL=1 -> sync pulses high and idle level 0.
